ts_gen: RTL and testbench
=========================

TS_GEN -- requirements
Module: ts_gen

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h47, sync byte emitted at packet offset 0.
REQ-002 Parameter PKT_LEN, default 188, bytes per packet; legal range 5..255.
REQ-003 Parameter GAP_CYCLES, default 0, idle cycles inserted between consecutive packets.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; low = block in reset.
REQ-006 enable  input  1  run request; high allows packet generation.
REQ-007 pid  input  13  PID placed in header bytes 1-2.
REQ-008 pkt_count  input  16  packets per run; 0 = unlimited.
REQ-009 payload_mode  input  2  0 = incrementing counter, 1 = constant 8'hFF, 2 = LFSR, 3 = treated as 0.
REQ-010 ts_out_d  output  8  stream byte.
REQ-011 ts_out_wrreq  output  1  ts_out_d valid this cycle, one byte per asserted cycle.
REQ-012 ts_out_almost_full  input  1  downstream backpressure.
REQ-013 pkt_start  output  1  high on the same cycle as the wrreq carrying the sync byte.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse with the last byte of the final packet of a bounded run.

Function
REQ-016 States: IDLE, SYNC, HDR1, HDR2, HDR3, PAYLOAD, GAP; a byte is issued only from SYNC..PAYLOAD.
REQ-017 IDLE -> SYNC when enable=1 and (pkt_count=0 or sent<pkt_count); otherwise IDLE is held.
REQ-018 While in IDLE with enable=0: 16-bit sent counter, 4-bit continuity counter cc, payload counter and LFSR clear (LFSR to 8'hFF).
REQ-019 Byte issue: in an issuing state with ts_out_almost_full=0 at a rising edge, the block registers ts_out_d and ts_out_wrreq=1 and advances; latency from that edge to visible wrreq is 0 cycles (registered output).
REQ-020 In an issuing state with ts_out_almost_full=1, ts_out_wrreq=0, and state, byte index and all counters hold.
REQ-021 Header: byte0 = SYNC_BYTE; byte1 = {1'b0, 1'b1 (PUSI), 1'b0, pid[12:8]}; byte2 = pid[7:0]; byte3 = {2'b00, 2'b01, cc}.
REQ-022 pid and payload_mode are captured when the sync byte issues and stay constant for the packet.
REQ-023 Payload bytes at offsets 4..PKT_LEN-1; 8-bit byte index counts 0..PKT_LEN-1 and exits PAYLOAD after offset PKT_LEN-1 issues.
REQ-024 Mode 0: value = payload counter, 8-bit, +1 per payload byte, wraps 255->0, continues across packets within a run.
REQ-025 Mode 2: value = LFSR, polynomial x^8+x^6+x^5+x^4+1, Fibonacci shift-left, advances once per payload byte issued.
REQ-026 After the last byte: cc increments (wraps 15->0); sent increments (saturates at 16'hFFFF); next state GAP if GAP_CYCLES>0, else the IDLE condition of REQ-017 is evaluated directly (back-to-back packets possible).
REQ-027 GAP counts GAP_CYCLES clocks, independent of backpressure, then returns to IDLE.
REQ-028 enable deasserted mid-packet: packet completes in full; no further packet starts.
REQ-029 done asserts with wrreq of the last byte when pkt_count!=0 and sent+1=pkt_count; never when pkt_count=0.
REQ-030 pkt_count changed mid-run is compared against sent on each IDLE evaluation; value <= sent ends the run at the next IDLE.

Reset
REQ-031 On reset low, asynchronously: state=IDLE, ts_out_d=0, ts_out_wrreq=0, pkt_start=0, busy=0, done=0, sent=0, cc=0, payload counter=0, LFSR=8'hFF.
REQ-032 Reset mid-packet aborts the packet immediately; a partial packet is not completed after release.
REQ-033 First packet may begin on the first rising edge after release if REQ-017 holds.

Verification
REQ-034 pid=13'h0100, pkt_count=1, mode 0, no backpressure -> 188 consecutive wrreq cycles: 47 41 00 10 00 01 .. B7; pkt_start on byte 0; done on byte 187.
REQ-035 pkt_count=17, mode 1 -> 17 packets, byte3 cc field 0..15 then 0; all payload 8'hFF; done once.
REQ-036 ts_out_almost_full high for 10 cycles at offset 50 -> wrreq gaps exactly 10 cycles, byte sequence unbroken, total 188 bytes.
REQ-037 enable dropped at offset 100, pkt_count=0 -> packet ends at offset 187, busy falls, no further wrreq.
REQ-038 reset low at offset 60 -> wrreq=0 same cycle; after release with enable=1 next byte is 8'h47 with cc=0.
REQ-039 Output fed to ts_filter with PID enabled -> filter output matches generated stream byte-for-byte.

Source files
------------

// File: rtl/ts_gen_if.sv
// rtl/ts_gen_if.sv - transport stream byte output bus between generator and sink
interface ts_gen_if;
    logic [7:0] ts_out_d;
    logic       ts_out_wrreq;
    logic       ts_out_almost_full;
    logic       pkt_start;
    logic       done;

    modport master (
        output ts_out_d,
        output ts_out_wrreq,
        output pkt_start,
        output done,
        input  ts_out_almost_full
    );

    modport slave (
        input  ts_out_d,
        input  ts_out_wrreq,
        input  pkt_start,
        input  done,
        output ts_out_almost_full
    );
endinterface

// File: rtl/ts_gen.sv
// rtl/ts_gen.sv - MPEG transport stream packet generator with selectable payload
module ts_gen #(
    parameter logic [7:0] SYNC_BYTE  = 8'h47,
    parameter int         PKT_LEN    = 188,
    parameter int         GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [12:0] pid,
    input  logic [15:0] pkt_count,
    input  logic [1:0]  payload_mode,
    output logic        busy,
    ts_gen_if.master    ts
);

    typedef enum logic [2:0] {IDLE, SYNC, HDR1, HDR2, HDR3, PAYLOAD, GAP} state_t;

    localparam logic [7:0]  LAST_IDX = 8'(PKT_LEN - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  idx;
    logic [15:0] sent;
    logic [3:0]  cc;
    logic [7:0]  pay_cnt;
    logic [7:0]  lfsr;
    logic [12:0] pid_q;
    logic [1:0]  mode_q;
    logic [15:0] gap_cnt;
    logic [7:0]  d_q;
    logic        wrreq_q, start_q, done_q;

    logic        issuing, fire, last, final_pkt, run_ok, run_ok_after;
    logic [15:0] sent_inc;
    logic [7:0]  byte_val;
    logic [7:0]  lfsr_nxt;

    assign issuing      = (state == SYNC) || (state == HDR1) || (state == HDR2) ||
                          (state == HDR3) || (state == PAYLOAD);
    assign fire         = issuing && !ts.ts_out_almost_full;
    assign last         = (state == PAYLOAD) && (idx == LAST_IDX);
    assign sent_inc     = (&sent) ? sent : sent + 16'd1;
    assign run_ok       = enable && ((pkt_count == 16'd0) || (sent < pkt_count));
    // Back-to-back decision happens on the same edge that bumps sent, so look ahead.
    assign run_ok_after = enable && ((pkt_count == 16'd0) || (sent_inc < pkt_count));
    assign final_pkt    = (pkt_count != 16'd0) &&
                          (({1'b0, sent} + 17'd1) == {1'b0, pkt_count});
    assign lfsr_nxt     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    assign busy                = (state != IDLE);
    assign ts.ts_out_d         = d_q;
    assign ts.ts_out_wrreq     = wrreq_q;
    assign ts.pkt_start        = start_q;
    assign ts.done             = done_q;

    // Select the byte the current state would emit.
    always_comb begin
        byte_val = 8'h00;
        case (state)
            SYNC:    byte_val = SYNC_BYTE;
            HDR1:    byte_val = {3'b010, pid_q[12:8]};
            HDR2:    byte_val = pid_q[7:0];
            HDR3:    byte_val = {4'b0001, cc};
            PAYLOAD: begin
                case (mode_q)
                    2'd1:    byte_val = 8'hFF;
                    2'd2:    byte_val = lfsr;
                    default: byte_val = pay_cnt;
                endcase
            end
            default: byte_val = 8'h00;
        endcase
    end

    // Next-state logic; issuing states advance only on an accepted byte.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run_ok) state_nxt = SYNC;
            SYNC:    if (fire) state_nxt = HDR1;
            HDR1:    if (fire) state_nxt = HDR2;
            HDR2:    if (fire) state_nxt = HDR3;
            HDR3:    if (fire) state_nxt = PAYLOAD;
            PAYLOAD: begin
                if (fire && last) begin
                    if (GAP_CYCLES > 0)    state_nxt = GAP;
                    else if (run_ok_after) state_nxt = SYNC;
                    else                   state_nxt = IDLE;
                end
            end
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Output registers, header capture and run/packet counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q     <= 8'h00;
            wrreq_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            idx     <= 8'd0;
            sent    <= 16'd0;
            cc      <= 4'd0;
            pay_cnt <= 8'd0;
            lfsr    <= 8'hFF;
            pid_q   <= 13'd0;
            mode_q  <= 2'd0;
            gap_cnt <= 16'd0;
        end else begin
            wrreq_q <= fire;
            start_q <= fire && (state == SYNC);
            done_q  <= fire && last && final_pkt;
            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
            if (fire) begin
                d_q <= byte_val;
                idx <= last ? 8'd0 : idx + 8'd1;
            end
            if (fire && (state == SYNC)) begin
                pid_q  <= pid;
                mode_q <= payload_mode;
            end
            if (fire && (state == PAYLOAD)) begin
                if (mode_q == 2'd2)      lfsr    <= lfsr_nxt;
                else if (mode_q != 2'd1) pay_cnt <= pay_cnt + 8'd1;
            end
            if (fire && last) begin
                cc   <= cc + 4'd1;
                sent <= sent_inc;
            end
            if ((state == IDLE) && !enable) begin
                sent    <= 16'd0;
                cc      <= 4'd0;
                pay_cnt <= 8'd0;
                lfsr    <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_ts_gen.sv
// tb/tb_ts_gen.sv - directed table-driven bench for ts_gen
module tb_ts_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        g_en = 1'b0;
    logic [12:0] pid = 13'd0;
    logic [15:0] pkt_count = 16'd0;
    logic [1:0]  mode = 2'd0;
    logic        busy, g_busy;

    ts_gen_if bus();
    ts_gen_if gbus();

    always #5 clk = ~clk;

    ts_gen u_dut (
        .clk(clk), .reset(reset), .enable(enable), .pid(pid), .pkt_count(pkt_count),
        .payload_mode(mode), .busy(busy), .ts(bus)
    );

    ts_gen #(.SYNC_BYTE(8'h47), .PKT_LEN(6), .GAP_CYCLES(2)) u_gap (
        .clk(clk), .reset(reset), .enable(g_en), .pid(pid), .pkt_count(pkt_count),
        .payload_mode(mode), .busy(g_busy), .ts(gbus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic       cap = 1'b0;
    logic       g_cap = 1'b0;
    int         cyc = 0;
    int         n_done = 0;
    logic [7:0] bytes[$];
    int         cycs[$];
    logic       st[$];
    logic       dn[$];
    logic [7:0] g_bytes[$];
    int         g_cycs[$];
    logic       g_dn[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!cap) begin
            bytes.delete(); cycs.delete(); st.delete(); dn.delete();
            n_done <= 0;
        end else if (bus.ts_out_wrreq) begin
            bytes.push_back(bus.ts_out_d);
            cycs.push_back(cyc);
            st.push_back(bus.pkt_start);
            dn.push_back(bus.done);
            if (bus.done) n_done <= n_done + 1;
        end
        if (!g_cap) begin
            g_bytes.delete(); g_cycs.delete(); g_dn.delete();
        end else if (gbus.ts_out_wrreq) begin
            g_bytes.push_back(gbus.ts_out_d);
            g_cycs.push_back(cyc);
            g_dn.push_back(gbus.done);
        end
    end

    typedef struct {
        logic [12:0] pid;
        logic [15:0] cnt;
        logic [1:0]  mode;
        int          nbytes;
        logic [7:0]  b1, b2, p0, p1, p8;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (n_done == 0 && t < budget) begin step(); t++; end
        if (n_done == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int t = 0;
        while (bytes.size() < n && t < budget) begin step(); t++; end
        if (bytes.size() < n) chk("bytes_timeout", bytes.size(), n);
    endtask

    task automatic begin_run(input logic [12:0] p, input logic [15:0] c, input logic [1:0] m);
        enable = 1'b0;
        cap = 1'b0;
        repeat (2) step();
        pid = p; pkt_count = c; mode = m;
        cap = 1'b1;
        enable = 1'b1;
    endtask

    task automatic end_run();
        enable = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        logic [7:0] hdr[4];
        logic [7:0] g_exp[12];
        int e0, e1, e2;

        hdr = '{8'h47, 8'h41, 8'h00, 8'h10};
        g_exp = '{8'h47, 8'h40, 8'h05, 8'h10, 8'h00, 8'h01,
                  8'h47, 8'h40, 8'h05, 8'h11, 8'h02, 8'h03};
        vecs[0] = '{13'h0100, 16'd1, 2'd0, 188, 8'h41, 8'h00, 8'h00, 8'h01, 8'h08};
        vecs[1] = '{13'h1FFF, 16'd1, 2'd1, 188, 8'h5F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[2] = '{13'h0ABC, 16'd1, 2'd2, 188, 8'h4A, 8'hBC, 8'hFF, 8'hFE, 8'h0B};
        vecs[3] = '{13'h0000, 16'd2, 2'd0, 376, 8'h40, 8'h00, 8'h00, 8'h01, 8'h08};
        vecs[4] = '{13'h0123, 16'd1, 2'd3, 188, 8'h41, 8'h23, 8'h00, 8'h01, 8'h08};
        bus.ts_out_almost_full = 1'b0;
        gbus.ts_out_almost_full = 1'b0;

        // reset state
        repeat (3) step();
        chk("rst_wrreq", bus.ts_out_wrreq, 0);
        chk("rst_d", bus.ts_out_d, 0);
        chk("rst_start", bus.pkt_start, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gap_wrreq", gbus.ts_out_wrreq, 0);
        reset = 1'b1;
        step();

        // table: header, payload mode and run length per vector
        for (int v = 0; v < 5; v++) begin
            begin_run(vecs[v].pid, vecs[v].cnt, vecs[v].mode);
            wait_done(vecs[v].nbytes + 50);
            end_run();
            chk($sformatf("vec%0d_len", v), bytes.size(), vecs[v].nbytes);
            chk($sformatf("vec%0d_ndone", v), n_done, 1);
            if (bytes.size() >= 188) begin
                chk($sformatf("vec%0d_b0", v), bytes[0], 8'h47);
                chk($sformatf("vec%0d_b1", v), bytes[1], vecs[v].b1);
                chk($sformatf("vec%0d_b2", v), bytes[2], vecs[v].b2);
                chk($sformatf("vec%0d_b3", v), bytes[3], 8'h10);
                chk($sformatf("vec%0d_p0", v), bytes[4], vecs[v].p0);
                chk($sformatf("vec%0d_p1", v), bytes[5], vecs[v].p1);
                chk($sformatf("vec%0d_p8", v), bytes[12], vecs[v].p8);
                chk($sformatf("vec%0d_start", v), st[0], 1);
                chk($sformatf("vec%0d_done_pos", v), dn[vecs[v].nbytes - 1], 1);
            end
        end

        // full single packet, byte by byte
        begin_run(13'h0100, 16'd1, 2'd0);
        wait_done(400);
        end_run();
        chk("s34_len", bytes.size(), 188);
        e0 = 0; e1 = 0; e2 = 0;
        for (int i = 0; i < bytes.size() && i < 188; i++) begin
            if (bytes[i] !== ((i < 4) ? hdr[i] : 8'(i - 4))) e0++;
            if (cycs[i] != cycs[0] + i) e1++;
            if (st[i] !== (i == 0) || dn[i] !== (i == 187)) e2++;
        end
        chk("s34_bytes", e0, 0);
        chk("s34_contig", e1, 0);
        chk("s34_start_done", e2, 0);

        // 17 packets, constant payload, cc wrap
        begin_run(13'h0100, 16'd17, 2'd1);
        wait_done(17 * 188 + 100);
        end_run();
        chk("s35_len", bytes.size(), 17 * 188);
        chk("s35_ndone", n_done, 1);
        if (bytes.size() == 17 * 188) begin
            e0 = 0; e1 = 0; e2 = 0;
            for (int k = 0; k < 17; k++) begin
                if (bytes[k * 188 + 3] !== (8'h10 | 8'(k % 16))) e0++;
                if (st[k * 188] !== 1'b1) e2++;
            end
            for (int i = 0; i < 17 * 188; i++)
                if ((i % 188) >= 4 && bytes[i] !== 8'hFF) e1++;
            chk("s35_cc", e0, 0);
            chk("s35_payload", e1, 0);
            chk("s35_starts", e2, 0);
            chk("s35_back_to_back", cycs[17 * 188 - 1] - cycs[0], 17 * 188 - 1);
        end

        // backpressure for 10 cycles at offset 50
        begin_run(13'h0100, 16'd1, 2'd0);
        wait_bytes(50, 200);
        bus.ts_out_almost_full = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.ts_out_almost_full = 1'b0;
        wait_done(400);
        end_run();
        chk("s36_len", bytes.size(), 188);
        if (bytes.size() == 188) begin
            e0 = 0;
            for (int i = 4; i < 188; i++)
                if (bytes[i] !== 8'(i - 4)) e0++;
            chk("s36_bytes", e0, 0);
            chk("s36_gap", cycs[50] - cycs[49], 11);
            chk("s36_tail", cycs[187] - cycs[50], 137);
        end

        // enable dropped mid-packet on an unlimited run
        begin_run(13'h0100, 16'd0, 2'd0);
        wait_bytes(100, 300);
        enable = 1'b0;
        repeat (300) step();
        chk("s37_len", bytes.size(), 188);
        chk("s37_busy", busy, 0);
        chk("s37_ndone", n_done, 0);
        if (bytes.size() >= 188) chk("s37_last", bytes[187], 8'hB7);

        // gap insertion on the short-packet instance
        pid = 13'h0005; pkt_count = 16'd2; mode = 2'd0;
        g_cap = 1'b1;
        g_en = 1'b1;
        for (int t = 0; t < 100 && g_bytes.size() < 12; t++) step();
        g_en = 1'b0;
        repeat (10) step();
        chk("gap_len", g_bytes.size(), 12);
        if (g_bytes.size() == 12) begin
            e0 = 0;
            for (int i = 0; i < 12; i++)
                if (g_bytes[i] !== g_exp[i]) e0++;
            chk("gap_bytes", e0, 0);
            chk("gap_idle", g_cycs[6] - g_cycs[5], 4);
            chk("gap_pkt_contig", g_cycs[5] - g_cycs[0], 5);
            chk("gap_done_last", g_dn[11], 1);
            chk("gap_done_first", g_dn[5], 0);
        end

        // reset at offset 60 aborts the packet
        begin_run(13'h0100, 16'd0, 2'd0);
        for (int i = 0; i < 3; i++) wait_bytes(20 * (i + 1), 100);
        reset = 1'b0;
        #1;
        chk("s38_wrreq", bus.ts_out_wrreq, 0);
        chk("s38_busy", busy, 0);
        chk("s38_start", bus.pkt_start, 0);
        step();
        cap = 1'b0;
        step();
        reset = 1'b1;
        cap = 1'b1;
        wait_bytes(5, 50);
        if (bytes.size() >= 5) begin
            chk("s38_sync", bytes[0], 8'h47);
            chk("s38_cc", bytes[3], 8'h10);
            chk("s38_payload", bytes[4], 8'h00);
        end
        chk("s38_first_edge", cycs[0] - cycs[0] + ((bytes.size() >= 1) ? st[0] : 1'b0), 1);
        end_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
